// File: rtl/array_copy_engine.sv
// array_copy_engine: word-granular block move on the data-memory port.
// Each word takes one READ, one WAIT (capture read data) and one WRITE cycle.
// The optional macro ARRAY_COPY_MEMMOVE_EN adds descending copies for
// overlapping regions where the destination lies above the source.
// Without the macro the copy is always ascending, which gives memcpy semantics.
module array_copy_engine #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LEN_W          = 16,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_copied,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BYTES_PER_WORD);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [DATA_W-1:0] data_q, data_d;

`ifdef ARRAY_COPY_MEMMOVE_EN
    // Wide enough that src + length*BYTES_PER_WORD never wraps in the overlap test.
    localparam int EXT_W = ADDR_W + LEN_W + 8;

    logic              desc_q, desc_d;
    logic              desc_start;
    logic [ADDR_W-1:0] last_off;
    logic [EXT_W-1:0]  src_end_ext;

    // Decide copy direction and the offset of the last word for an accepted start.
    always_comb begin
        src_end_ext = EXT_W'(src_addr) + EXT_W'(length) * EXT_W'(BYTES_PER_WORD);
        desc_start  = (length != '0) && (dst_addr > src_addr) &&
                      (EXT_W'(dst_addr) < src_end_ext);
        last_off    = ADDR_W'(length - LEN_W'(1)) * STEP;
    end
`endif

    // Next-state and datapath update for the copy sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        cnt_d     = cnt_q;
        words_d   = words_q;
        data_d    = data_q;
`ifdef ARRAY_COPY_MEMMOVE_EN
        desc_d    = desc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_ptr_d = src_addr;
                    dst_ptr_d = dst_addr;
                    cnt_d     = length;
                    words_d   = '0;
`ifdef ARRAY_COPY_MEMMOVE_EN
                    desc_d    = desc_start;
                    if (desc_start) begin
                        src_ptr_d = src_addr + last_off;
                        dst_ptr_d = dst_addr + last_off;
                    end
`endif
                    state_d   = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                data_d  = mem_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: begin
`ifdef ARRAY_COPY_MEMMOVE_EN
                if (desc_q) begin
                    src_ptr_d = src_ptr_q - STEP;
                    dst_ptr_d = dst_ptr_q - STEP;
                end else begin
                    src_ptr_d = src_ptr_q + STEP;
                    dst_ptr_d = dst_ptr_q + STEP;
                end
`else
                src_ptr_d = src_ptr_q + STEP;
                dst_ptr_d = dst_ptr_q + STEP;
`endif
                cnt_d   = cnt_q - LEN_W'(1);
                words_d = words_q + LEN_W'(1);
                state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_READ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            cnt_q     <= '0;
            words_q   <= '0;
            data_q    <= '0;
`ifdef ARRAY_COPY_MEMMOVE_EN
            desc_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            cnt_q     <= cnt_d;
            words_q   <= words_d;
            data_q    <= data_d;
`ifdef ARRAY_COPY_MEMMOVE_EN
            desc_q    <= desc_d;
`endif
        end
    end

    // Moore outputs decoded from the current state; address and data are zero outside READ/WRITE.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        words_copied = words_q;
        case (state_q)
            S_READ: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = src_ptr_q;
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            S_WRITE: begin
                busy      = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = dst_ptr_q;
                mem_wdata = data_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_array_copy_engine.sv
// Self-checking bench for array_copy_engine: directed scenarios plus random copies
// checked cycle by cycle against a word-level memory reference model.
// Honours ARRAY_COPY_MEMMOVE_EN for the expected copy direction.
module tb_array_copy_engine;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LW  = 16;
    localparam int BPW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_copied;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    array_copy_engine #(
        .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .BYTES_PER_WORD(BPW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .length(length),
        .busy(busy),
        .done(done),
        .words_copied(words_copied),
        .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory seen by the DUT, and the reference image it should end up matching.
    logic [DW-1:0] mem     [logic [AW-1:0]];
    logic [DW-1:0] exp_mem [logic [AW-1:0]];

    int            n_cmp = 0;
    int            n_err = 0;
    logic          prev_rd = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    function automatic logic [DW-1:0] rd_exp(input logic [AW-1:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : '0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem[a]     = d;
        exp_mem[a] = d;
    endtask

    // Advance one cycle and service the memory port: read data appears exactly
    // one cycle after the strobe (random junk otherwise); writes commit.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = prev_rd ? rd_mem(prev_addr) : $urandom;
        prev_rd   = mem_rd_en;
        prev_addr = mem_addr;
        if (mem_wr_en) mem[mem_addr] = mem_wdata;
    endtask

    task automatic compare_memory(input string tag);
        foreach (exp_mem[a]) check($sformatf("%s mem[%0h]", tag, a), rd_mem(a), exp_mem[a]);
    endtask

    // One complete copy, checked every cycle. With hammer set, start stays high and the
    // inputs are scrambled every cycle until the engine is back in IDLE.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                            input bit hammer, output logic [AW-1:0] first_rd,
                            output logic [AW-1:0] first_wr);
        logic [AW-1:0] ra[$];
        logic [AW-1:0] wa[$];
        logic [DW-1:0] wd[$];
        bit            desc;
        bit            seen_rd;
        bit            seen_wr;
        int            last;
        desc = 1'b0;
`ifdef ARRAY_COPY_MEMMOVE_EN
        desc = (n != 0) && (d > s) && (longint'(d) < longint'(s) + longint'(n) * BPW);
`endif
        // Reference: words move one at a time, ascending or (memmove case) descending.
        for (int k = 0; k < int'(n); k++) begin
            int            idx;
            logic [AW-1:0] off;
            logic [DW-1:0] v;
            idx = desc ? int'(n) - 1 - k : k;
            off = AW'(idx * BPW);
            v   = rd_exp(s + off);
            exp_mem[d + off] = v;
            ra.push_back(s + off);
            wa.push_back(d + off);
            wd.push_back(v);
        end
        first_rd = '1;
        first_wr = '1;
        seen_rd  = 1'b0;
        seen_wr  = 1'b0;
        last     = 3 * int'(n) + 2;
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        length   = n;
        for (int c = 1; c <= last; c++) begin
            bit exp_rd;
            bit exp_wr;
            int w;
            tick();
            exp_rd = (c <= 3 * int'(n)) && (c % 3 == 1);
            exp_wr = (c <= 3 * int'(n)) && (c % 3 == 0);
            w      = (c - 1) / 3;
            check($sformatf("c%0d rd_en", c), mem_rd_en, exp_rd);
            check($sformatf("c%0d wr_en", c), mem_wr_en, exp_wr);
            check($sformatf("c%0d busy", c), busy, (n != 0) && (c <= 3 * int'(n)));
            check($sformatf("c%0d done", c), done, c == 3 * int'(n) + 1);
            if (exp_rd) check($sformatf("c%0d rd_addr", c), mem_addr, ra[w]);
            if (exp_wr) begin
                check($sformatf("c%0d wr_addr", c), mem_addr, wa[w]);
                check($sformatf("c%0d wdata", c), mem_wdata, wd[w]);
            end
            if (!exp_rd && !exp_wr) check($sformatf("c%0d idle_addr", c), mem_addr, 0);
            if (mem_rd_en && !seen_rd) begin first_rd = mem_addr; seen_rd = 1'b1; end
            if (mem_wr_en && !seen_wr) begin first_wr = mem_addr; seen_wr = 1'b1; end
            if (c == 3 * int'(n) + 1) check("words_copied at done", words_copied, n);
            start = hammer && (c < last);
            if (hammer) begin
                src_addr = $urandom;
                dst_addr = $urandom;
                length   = LW'($urandom_range(1, 20));
            end
        end
        start = 1'b0;
        check("words_copied held", words_copied, n);
        compare_memory("copy");
    endtask

    logic [AW-1:0] frd;
    logic [AW-1:0] fwr;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        length    = '0;
        mem_rdata = '0;

        // Reset values.
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset rd_en", mem_rd_en, 0);
        check("reset wr_en", mem_wr_en, 0);
        check("reset addr", mem_addr, 0);
        check("reset wdata", mem_wdata, 0);
        check("reset words", words_copied, 0);
        rst = 1'b0;
        tick();

        // Five-word disjoint copy.
        for (int i = 0; i < 5; i++) poke(AW'(4 * i), DW'(32'h1111_1111 * (i + 1)));
        run_copy(32'h0, 32'h40, 16'd5, 1'b0, frd, fwr);
        for (int i = 0; i < 5; i++)
            check($sformatf("t1 dst%0d", i), rd_mem(AW'(32'h40 + 4 * i)), 32'h1111_1111 * (i + 1));
        check("t1 first rd", frd, 32'h0);
        check("t1 first wr", fwr, 32'h40);
        tick();

        // Zero-length copy: one-cycle done, no memory traffic.
        run_copy(32'h10, 32'h20, 16'd0, 1'b0, frd, fwr);
        check("t2 no rd", frd, 32'hFFFF_FFFF);
        check("t2 no wr", fwr, 32'hFFFF_FFFF);
        tick();

        // Reset during an eight-word copy, after the second write.
        for (int i = 0; i < 8; i++) begin
            poke(AW'(4 * i), DW'($urandom));
            poke(AW'(32'h40 + 4 * i), DW'(32'hDEAD_0000 + i));
        end
        start    = 1'b1;
        src_addr = 32'h0;
        dst_addr = 32'h40;
        length   = 16'd8;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 7; c++) tick();
        check("t3 words before rst", words_copied, 2);
        exp_mem[32'h40] = rd_exp(32'h0);
        exp_mem[32'h44] = rd_exp(32'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t3 rd_en %0d", c), mem_rd_en, 0);
            check($sformatf("t3 wr_en %0d", c), mem_wr_en, 0);
            check($sformatf("t3 busy %0d", c), busy, 0);
            check($sformatf("t3 done %0d", c), done, 0);
            check($sformatf("t3 words %0d", c), words_copied, 0);
            tick();
        end
        compare_memory("t3");

        // start held high and inputs scrambled during a three-word copy.
        for (int i = 0; i < 3; i++) poke(AW'(32'h200 + 4 * i), DW'($urandom));
        run_copy(32'h200, 32'h300, 16'd3, 1'b1, frd, fwr);
        tick();
        check("t4 no relaunch busy", busy, 0);
        check("t4 no relaunch rd", mem_rd_en, 0);

        // Source address wraps past the top of the address space.
        poke(32'hFFFF_FFFC, 32'hCAFE_0001);
        poke(32'h0000_0000, 32'hCAFE_0002);
        run_copy(32'hFFFF_FFFC, 32'h100, 16'd2, 1'b0, frd, fwr);
        check("t5 first rd", frd, 32'hFFFF_FFFC);
        check("t5 wrapped word", rd_mem(32'h104), 32'hCAFE_0002);
        tick();

        // Overlapping copy with destination above source.
        poke(32'h0, 32'hAAAA_AAAA);
        poke(32'h4, 32'hBBBB_BBBB);
        poke(32'h8, 32'hCCCC_CCCC);
        poke(32'hC, 32'hDDDD_DDDD);
        run_copy(32'h0, 32'h8, 16'd4, 1'b0, frd, fwr);
`ifdef ARRAY_COPY_MEMMOVE_EN
        check("t6 dst0", rd_mem(32'h08), 32'hAAAA_AAAA);
        check("t6 dst1", rd_mem(32'h0C), 32'hBBBB_BBBB);
        check("t6 dst2", rd_mem(32'h10), 32'hCCCC_CCCC);
        check("t6 dst3", rd_mem(32'h14), 32'hDDDD_DDDD);
        check("t6 first rd", frd, 32'h0C);
        check("t6 first wr", fwr, 32'h14);
`else
        check("t6 dst0", rd_mem(32'h08), 32'hAAAA_AAAA);
        check("t6 dst1", rd_mem(32'h0C), 32'hBBBB_BBBB);
        check("t6 dst2", rd_mem(32'h10), 32'hAAAA_AAAA);
        check("t6 dst3", rd_mem(32'h14), 32'hBBBB_BBBB);
        check("t6 first rd", frd, 32'h00);
        check("t6 first wr", fwr, 32'h08);
`endif
        tick();

        // Random copies inside a small window so overlaps in both directions occur.
        for (int i = 0; i < 64; i++) poke(AW'(32'h400 + 4 * i), DW'($urandom));
        for (int t = 0; t < 12; t++) begin
            logic [AW-1:0] rs;
            logic [AW-1:0] rdst;
            logic [LW-1:0] rn;
            rs   = AW'(32'h400 + 4 * $urandom_range(0, 40));
            rdst = AW'(32'h400 + 4 * $urandom_range(0, 40));
            rn   = LW'($urandom_range(0, 10));
            run_copy(rs, rdst, rn, 1'b0, frd, fwr);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/array_copy_engine.md
Name: array_copy_engine

Overview:
- Parametrised hardware array-copy engine (word-granular block move) sitting beside the MIPS core on the data-memory port.
- Replaces the software array-copy loop: the host loads source address, destination address and word count, then pulses start.
- The engine copies with one read followed by one write per word. It reports busy, a done pulse and a running copy count.
- Data memory is byte-addressed and big-endian; word addresses advance by BYTES_PER_WORD.

Parameters:
- ADDR_W, 32, width of byte addresses.
- DATA_W, 32, data word width in bits.
- LEN_W, 16, width of the word-count field.
- BYTES_PER_WORD, 4, address increment per word; must equal DATA_W/8.

Ports:
- clk  in  1  single clock, all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- src_addr  in  ADDR_W  first source byte address, latched on accepted start.
- dst_addr  in  ADDR_W  first destination byte address, latched on accepted start.
- length  in  LEN_W  number of words to copy, latched on accepted start.
- busy  out  1  high while a copy is in progress.
- done  out  1  one-cycle pulse when a copy finishes.
- words_copied  out  LEN_W  number of words written so far in the current or last copy.
- mem_rd_en  out  1  read strobe.
- mem_wr_en  out  1  write strobe.
- mem_addr  out  ADDR_W  byte address for the current read or write.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid exactly one cycle after mem_rd_en.

Behaviour:
- Reset, synchronous, active-high: state=IDLE; busy, done, mem_rd_en and mem_wr_en = 0; mem_addr, mem_wdata and words_copied = 0.
- Reset asserted mid-copy: the engine aborts with no further strobes from the next edge. Memory already written stays written.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE + start=1:
  - Latch src/dst/length into src_ptr, dst_ptr and cnt; clear words_copied.
  - If length=0, go to DONE with no memory access.
  - Otherwise go to READ; busy=1 from the next cycle.
- READ: mem_rd_en=1, mem_addr=src_ptr; go to WAIT.
- WAIT: capture mem_rdata into the data register; go to WRITE.
- WRITE:
  - mem_wr_en=1, mem_addr=dst_ptr, mem_wdata=captured word.
  - Advance src_ptr and dst_ptr by BYTES_PER_WORD, decrement cnt, increment words_copied.
  - Next state is DONE if cnt was 1, otherwise READ.
- DONE: done=1 for exactly one cycle, busy=0; return to IDLE.
- Throughput: 3 cycles per word. From start to done is 3N+1 cycles for N>0, and 1 cycle for N=0.
- Strobes: mem_rd_en and mem_wr_en are never high in the same cycle. Both are 0 in IDLE and DONE.
- start while busy or in DONE is ignored; no queueing.
- start held high across DONE→IDLE launches a new copy, re-latching the inputs in the IDLE cycle.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top is silent.
- No alignment check: addresses are used as given.
- Overlapping regions without the optional feature: copy is strictly ascending, so memcpy semantics apply. A destination above the source inside the region propagates the source head.
- words_copied holds its final value after done until the next accepted start or reset.

Optional Feature:
- Macro: ARRAY_COPY_MEMMOVE_EN.
- Defined, start phase: on an accepted start with length>0, dst_addr>src_addr (unsigned) and dst_addr < src_addr + length*BYTES_PER_WORD, the engine copies descending.
- Defined, descending copy:
  - Pointers start at src_addr+(length-1)*BYTES_PER_WORD and dst_addr+(length-1)*BYTES_PER_WORD.
  - Pointers decrement by BYTES_PER_WORD after each WRITE.
  - Timing and handshakes are identical to the ascending copy.
  - Result equals memmove.
- Defined, otherwise: ascending copy.
- Not defined: the direction logic is absent; ascending copy always.

Test Plan:
1. Reset, then src=0x00, dst=0x40, length=5 with words 0x11111111..0x55555555 → five read/write pairs, dst words 0x40..0x50 match the source, done 16 cycles after the start edge, words_copied=5.
2. length=0, src=0x10, dst=0x20 → done pulses 1 cycle after start, no mem_rd_en or mem_wr_en, busy never high, words_copied=0.
3. Copy started with length=8, rst asserted after the 2nd write → strobes stop next cycle; only 0x40 and 0x44 are written; busy=0 and done=0 afterwards.
4. start re-pulsed every cycle during a length=3 copy → only one copy occurs and a single done pulse; the inputs changed mid-copy have no effect.
5. src=0xFFFFFFFC, dst=0x100, length=2 → reads 0xFFFFFFFC then 0x00000000 (wrap).
6. src=0x00, dst=0x08, length=4 with words A,B,C,D → without macro, dst holds A,B,A,B. With ARRAY_COPY_MEMMOVE_EN, dst holds A,B,C,D, the first read is at 0x0C, and the first write is at 0x14.
